// File: rtl/if_stage.sv
// RV64I instruction fetch: owns the PC, keeps one fetch outstanding on imem,
// and fills the IF/ID register; a one-entry skid holds a response caught by stall.
module if_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instr
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        KILL
    } state_e;

    state_e      state_q;
    state_e      state_d;
    logic [63:0] pc_q;
    logic [63:0] req_pc_q;
    logic        skid_valid;
    logic [63:0] skid_pc;
    logic [31:0] skid_instr;

    logic        grant;
    logic        resp_live;
    logic        resp_ok;
    logic        sel_flush;
    logic        sel_hold;
    logic        sel_skid;
    logic        sel_resp;

    assign imem_req  = !rst && !stall && !redirect_valid && !skid_valid &&
                       (state_q == IDLE || imem_rvalid);
    assign imem_addr = pc_q;
    assign grant     = imem_req && imem_gnt;

    // A response closes any outstanding fetch; only a WAIT one carries data.
    assign resp_live = imem_rvalid && (state_q != IDLE);
    assign resp_ok   = imem_rvalid && (state_q == WAIT) && !redirect_valid;

    assign sel_flush = redirect_valid;
    assign sel_hold  = !redirect_valid && stall;
    assign sel_skid  = !redirect_valid && !stall && skid_valid;
    assign sel_resp  = !redirect_valid && !stall && !skid_valid && resp_ok;

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            if (resp_live) begin
                state_d = IDLE;
            end else if (state_q == WAIT) begin
                state_d = KILL;
            end
        end else if (state_q == IDLE || imem_rvalid) begin
            state_d = grant ? WAIT : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            state_q <= state_d;
            if (redirect_valid) begin
                pc_q <= redirect_pc & ~64'd3;
            end else if (grant) begin
                pc_q     <= pc_q + 64'd4;
                req_pc_q <= pc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= NOP_INSTR;
        end else if (redirect_valid) begin
            skid_valid <= 1'b0;
        end else if (stall) begin
            if (resp_ok) begin
                skid_valid <= 1'b1;
                skid_pc    <= req_pc_q;
                skid_instr <= imem_rdata;
            end
        end else begin
            skid_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
        end else begin
            unique case (1'b1)
                sel_flush: begin
                    if_id_valid <= 1'b0;
                    if_id_instr <= NOP_INSTR;
                end
                sel_hold: ;
                sel_skid: begin
                    if_id_valid <= 1'b1;
                    if_id_pc    <= skid_pc;
                    if_id_instr <= skid_instr;
                end
                sel_resp: begin
                    if_id_valid <= 1'b1;
                    if_id_pc    <= req_pc_q;
                    if_id_instr <= imem_rdata;
                end
                default: begin
                    if_id_valid <= 1'b0;
                    if_id_instr <= NOP_INSTR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: streaming, stall/skid, redirect, ungranted
// requests and reset mid-fetch against a latency-programmable imem model.
module tb_if_stage;

    localparam logic [63:0] RST_PC = 64'h1000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;

    logic        gnt_en;
    logic        mem_clr;
    int          lat;
    int          cnt;
    logic [63:0] pend;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    if_stage #(
        .RESET_PC (RST_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_id_valid   (if_id_valid),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr)
    );

    assign imem_gnt = gnt_en;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0000;
    endfunction

    // Memory: rvalid exactly lat cycles after the grant cycle.
    always @(posedge clk) begin
        if (mem_clr) begin
            cnt         <= 0;
            pend        <= '0;
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
        end else begin
            imem_rvalid <= 1'b0;
            if (cnt == 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= word_of(pend);
            end
            if (cnt != 0) cnt <= cnt - 1;
            if (imem_req && imem_gnt) begin
                pend <= imem_addr;
                if (lat == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= word_of(imem_addr);
                end else begin
                    cnt <= lat - 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic v,
                            input logic [63:0] pc, input logic [31:0] ins);
        chk({tag, "_v"}, 64'(if_id_valid), 64'(v));
        chk({tag, "_pc"}, if_id_pc, pc);
        chk({tag, "_ins"}, 64'(if_id_instr), 64'(ins));
    endtask

    task automatic chk_req(input string tag, input logic r,
                           input logic [63:0] a);
        chk({tag, "_req"}, 64'(imem_req), 64'(r));
        if (r) chk({tag, "_addr"}, imem_addr, a);
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int l, input logic g);
        rst            = 1'b1;
        mem_clr        = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        lat            = l;
        gnt_en         = g;
        nxt();
        nxt();
        rst     = 1'b0;
        mem_clr = 1'b0;
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        mem_clr        = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        gnt_en         = 1'b1;
        lat            = 1;
        nxt();
        nxt();
        chk_req("rst", 1'b0, '0);
        chk_ifid("rst", 1'b0, '0, NOP);

        // Reset release and zero-wait streaming
        rst     = 1'b0;
        mem_clr = 1'b0;
        #1;
        for (int k = 1; k <= 8; k++) begin
            chk_req("strm", 1'b1, RST_PC + 64'(4 * (k - 1)));
            if (k >= 3)
                chk_ifid("strm", 1'b1, RST_PC + 64'(4 * (k - 3)),
                         word_of(RST_PC + 64'(4 * (k - 3))));
            else
                chk_ifid("strm", 1'b0, '0, NOP);
            nxt();
        end

        // Stall over an outstanding fetch, L=2
        do_reset(2, 1'b1);
        for (int k = 1; k < 6; k++) nxt();
        stall = 1'b1;
        #1;
        for (int c = 6; c <= 8; c++) begin
            chk_req("stl", 1'b0, '0);
            chk_ifid("stl", 1'b1, 64'h1004, word_of(64'h1004));
            nxt();
        end
        stall = 1'b0;
        #1;
        chk_req("stl_rel", 1'b0, '0);
        chk_ifid("stl_rel", 1'b1, 64'h1004, word_of(64'h1004));
        nxt();
        chk_ifid("stl_skid", 1'b1, 64'h1008, word_of(64'h1008));
        chk_req("stl_skid", 1'b1, 64'h100C);
        nxt();
        chk_ifid("stl_b1", 1'b0, 64'h1008, NOP);
        chk_req("stl_b1", 1'b0, '0);
        nxt();
        chk_ifid("stl_b2", 1'b0, 64'h1008, NOP);
        nxt();
        chk_ifid("stl_nx", 1'b1, 64'h100C, word_of(64'h100C));

        // Redirect while WAIT, L=3
        do_reset(3, 1'b1);
        for (int k = 1; k < 5; k++) nxt();
        chk_ifid("rdw_pre", 1'b1, 64'h1000, word_of(64'h1000));
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2002;
        #1;
        chk_req("rdw_cyc", 1'b0, '0);
        nxt();
        redirect_valid = 1'b0;
        #1;
        chk_ifid("rdw_fl", 1'b0, 64'h1000, NOP);
        chk_req("rdw_kill", 1'b0, '0);
        nxt();
        chk_req("rdw_tgt", 1'b1, 64'h2000);
        for (int c = 8; c <= 10; c++) begin
            nxt();
            chk_ifid("rdw_drop", 1'b0, 64'h1000, NOP);
        end
        nxt();
        chk_ifid("rdw_new", 1'b1, 64'h2000, word_of(64'h2000));

        // Redirect during stall with a full skid
        do_reset(2, 1'b1);
        for (int k = 1; k < 6; k++) nxt();
        stall = 1'b1;
        nxt();
        nxt();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h4000;
        #1;
        chk_req("rds_cyc", 1'b0, '0);
        nxt();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk_ifid("rds_fl", 1'b0, 64'h1004, NOP);
        chk_req("rds_tgt", 1'b1, 64'h4000);
        for (int c = 10; c <= 11; c++) begin
            nxt();
            chk_ifid("rds_b", 1'b0, 64'h1004, NOP);
        end
        nxt();
        chk_ifid("rds_new", 1'b1, 64'h4000, word_of(64'h4000));

        // Ungranted request, then redirect
        do_reset(1, 1'b0);
        chk_req("ung1", 1'b1, 64'h1000);
        chk_ifid("ung1", 1'b0, '0, NOP);
        nxt();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3000;
        #1;
        chk_req("ung_rd", 1'b0, '0);
        nxt();
        redirect_valid = 1'b0;
        #1;
        chk_req("ung3", 1'b1, 64'h3000);
        nxt();
        chk_req("ung4", 1'b1, 64'h3000);
        chk_ifid("ung4", 1'b0, '0, NOP);
        nxt();
        gnt_en = 1'b1;
        #1;
        chk_req("ung5", 1'b1, 64'h3000);
        nxt();
        chk_ifid("ung6", 1'b0, '0, NOP);
        nxt();
        chk_ifid("ung7", 1'b1, 64'h3000, word_of(64'h3000));

        // Reset mid-WAIT with a late response
        do_reset(3, 1'b1);
        for (int k = 1; k < 5; k++) nxt();
        chk_ifid("rmw_pre", 1'b1, 64'h1000, word_of(64'h1000));
        rst = 1'b1;
        #1;
        chk_req("rmw_rst", 1'b0, '0);
        nxt();
        rst   = 1'b0;
        stall = 1'b1;
        #1;
        chk_ifid("rmw_clr", 1'b0, '0, NOP);
        chk_req("rmw_clr", 1'b0, '0);
        nxt();
        chk_ifid("rmw_late", 1'b0, '0, NOP);
        nxt();
        stall = 1'b0;
        #1;
        chk_ifid("rmw_ign", 1'b0, '0, NOP);
        chk_req("rmw_re", 1'b1, RST_PC);
        for (int c = 9; c <= 11; c++) begin
            nxt();
            chk_ifid("rmw_b", 1'b0, '0, NOP);
        end
        nxt();
        chk_ifid("rmw_new", 1'b1, RST_PC, word_of(RST_PC));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage RV64I pipeline: owns the PC, issues fetches over a single-outstanding request/grant/response memory port, and drives the IF/ID pipeline register consumed by decode. It obeys the load-use `stall` produced by hazard detection and the branch/jump `redirect` from EX. Redirect outranks stall. A one-entry skid buffer ensures that a response landing during a stall is never lost or duplicated.

## Interface
- `RESET_PC`, default 64'h0: fetch address after reset; bits [1:0] must be 0.
- `NOP_INSTR`, default 32'h0000_0013: `addi x0,x0,0`, driven on `if_id_instr` when the slot is invalid.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: load-use stall; hold the PC and IF/ID, issue no request.
- `redirect_valid` in 1: taken branch/jump resolved in EX; flush and refetch.
- `redirect_pc` in 64: new fetch target; bits [1:0] are forced to 0 internally.
- `imem_req` out 1: fetch request.
- `imem_addr` out 64: fetch address, valid while `imem_req`=1.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: response data valid; at least 1 cycle after grant.
- `imem_rdata` in 32: instruction word.
- `if_id_valid` out 1: IF/ID slot holds a real instruction.
- `if_id_pc` out 64: PC of the IF/ID instruction.
- `if_id_instr` out 32: instruction; `NOP_INSTR` when `if_id_valid`=0.

## Operation
- **State.**
  - `pc_q`: next fetch address.
  - `req_pc_q`: PC of the outstanding request.
  - FSM: `IDLE` (nothing outstanding), `WAIT` (outstanding, keep), `KILL` (outstanding, discard).
  - Skid: `skid_valid`, `skid_pc`, `skid_instr`.
- **Request issue.**
  - `imem_req` = !`rst` & !`stall` & !`redirect_valid` & !`skid_valid` & (state==`IDLE` | `imem_rvalid`).
  - `imem_addr` = `pc_q`.
  - On `imem_req`&`imem_gnt`: `req_pc_q`<=`pc_q`, `pc_q`<=`pc_q`+4 (64-bit, wraps modulo 2^64), state<=`WAIT`.
  - Without a grant, the request may change or drop; memory samples the address only on grant.
- **Response.** `imem_rvalid` is ignored in `IDLE`.
  - In `WAIT`: data is tagged `req_pc_q`. If !`stall` it loads IF/ID directly; if `stall` it loads the skid. State goes to `IDLE` unless a new grant occurs in the same cycle, in which case it stays `WAIT`.
  - In `KILL`: data is dropped. State goes to `IDLE`, or to `WAIT` on a same-cycle grant.
- **IF/ID update priority.**
  1. `redirect_valid`: `if_id_valid`<=0, `if_id_instr`<=`NOP_INSTR`, `if_id_pc` held.
  2. `stall`: hold all IF/ID fields.
  3. `skid_valid`: load from skid, clear skid.
  4. Accepted `WAIT` response: load it.
  5. Otherwise: bubble (valid 0, NOP).
- **Redirect.** Applies regardless of `stall`.
  - `pc_q`<=`redirect_pc`&~3.
  - Skid cleared.
  - `WAIT`→`KILL`. If `imem_rvalid` arrives in the same cycle, that data is dropped and the state goes to `IDLE`.
  - `KILL` stays `KILL`.
  - No request is issued in the redirect cycle.
- **Reset.**
  - `pc_q`=`RESET_PC`, state `IDLE`, skid empty.
  - `if_id_valid`=0, `if_id_pc`=0, `if_id_instr`=`NOP_INSTR`.
  - `imem_req`=0 while `rst`=1.
  - Reset mid-`WAIT`/`KILL` abandons the request. A late `imem_rvalid` is ignored because the state is `IDLE`.

## Timing
- All outputs are registered except `imem_req`/`imem_addr`, which are combinational from state and the stall/redirect inputs.
- **Latency.** A grant in cycle N with `rvalid` in N+L puts the instruction in IF/ID visible in cycle N+L+1 (absent stall).
- **Throughput.** With zero wait states (`gnt`=1, L=1) the stage sustains one instruction per cycle.
- **Reset sequence.** First request in the cycle after `rst` falls; first valid IF/ID 2 cycles later.
- **Stall release.** The skid entry reaches IF/ID in the first non-stall cycle. The next request issues the cycle after the skid empties.
- **Redirect.** Redirect in cycle N puts the first request to the target in cycle N+1 if `IDLE`, otherwise once the killed response returns.
- **Ordering.** No duplicate or skipped PC in any stall/redirect interleaving.

## Test plan
- **Reset and streaming.** `RESET_PC`=0x1000, `gnt`=1, L=1 → `imem_addr` 0x1000, 0x1004, … from cycle 1; `if_id_pc` 0x1000 valid at cycle 3, then +4 every cycle.
- **Stall over an outstanding fetch.** L=2, `stall` held 3 cycles while 0x1008 is outstanding → IF/ID holds 0x1004, `imem_req`=0, 0x1008 lands in the skid; 0x1008 appears in IF/ID the cycle after release, then 0x100C.
- **Redirect in `WAIT`.** L=3, `redirect_pc`=0x2002 in `WAIT` → next cycle `if_id_valid`=0 / `NOP_INSTR`; stale data dropped; next `imem_addr`=0x2000.
- **Redirect during stall with full skid.** → flush wins: IF/ID invalid, skid cleared, refetch from the target.
- **Ungranted request and redirect.** `gnt` withheld 4 cycles → `imem_addr` stays 0x1000; redirect to 0x3000 in cycle 2 → `imem_req`=0 that cycle, then 0x3000; no PC 0x1000 instruction ever valid.
- **Reset mid-`WAIT`.** Assert `rst` during `WAIT`, `rvalid` arrives 2 cycles later → outputs at reset values, response ignored, fetch restarts at `RESET_PC`.
